// File: rtl/memory_responder.sv
// memory_responder: responder end of the CPU RAM strobe interface.
// Services single-cycle read/write strobes from an on-chip word RAM or a small
// MMIO block (cycle counter, timer compare + sticky irq, status, scratch).
// Optional feature macro: RESPONDER_WPROT_EN -- drops writes to 0..PROT_TOP
// and flags them as bus errors.
module memory_responder #(
  parameter int unsigned RAM_DEPTH = 4096,
  parameter logic [15:0] MMIO_BASE = 16'hFF00,
  parameter logic [15:0] PROT_TOP  = 16'h00FF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ram_address_in,
  input  logic [15:0] ram_data_in,
  input  logic        ram_read_en,
  input  logic        ram_write_en,
  output logic [15:0] ram_data_out,
  output logic        bus_error,
  output logic        timer_irq
);

  localparam int unsigned DW     = 16;
  localparam int unsigned CW     = 32;
  localparam int unsigned RAM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [16:0] MMIO_LAST = 17'(MMIO_BASE) + 17'd15;

  localparam logic [3:0] OFF_CYCLE_LO = 4'd0;
  localparam logic [3:0] OFF_CYCLE_HI = 4'd1;
  localparam logic [3:0] OFF_TIMER    = 4'd2;
  localparam logic [3:0] OFF_STATUS   = 4'd3;
  localparam logic [3:0] OFF_SCRATCH  = 4'd4;

  logic [DW-1:0] mem [RAM_DEPTH];

  logic [CW-1:0] cycle;
  logic [DW-1:0] cycle_hi_snap;
  logic [DW-1:0] timer_cmp;
  logic [DW-1:0] scratch;

  logic              is_ram_c;
  logic              is_mmio_c;
  logic [3:0]        off_c;
  logic [RAM_AW-1:0] ram_idx_c;
  logic              rd_c;
  logic              wr_c;
  logic              prot_hit_c;
  logic [DW-1:0]     rd_data_c;
  logic              err_set_c;
  logic              irq_set_c;
  logic              status_wr_c;

  // Address decode; a write takes priority over a simultaneous read.
  always_comb begin
    is_ram_c  = 32'(ram_address_in) < RAM_DEPTH;
    is_mmio_c = (ram_address_in >= MMIO_BASE) && (17'(ram_address_in) <= MMIO_LAST);
    off_c     = 4'(ram_address_in - MMIO_BASE);
    ram_idx_c = RAM_AW'(ram_address_in);
    rd_c      = ram_read_en & ~ram_write_en;
    wr_c      = ram_write_en;
  end

`ifdef RESPONDER_WPROT_EN
  // Low address range is read-only when write protection is built in.
  always_comb begin
    prot_hit_c = is_ram_c && (ram_address_in <= PROT_TOP);
  end
`else
  logic unused_prot_top;
  assign unused_prot_top = ^PROT_TOP;

  // No protected range in this build.
  always_comb begin
    prot_hit_c = 1'b0;
  end
`endif

  // Read data mux for RAM, MMIO registers and unmapped space.
  always_comb begin
    rd_data_c = '0;
    if (is_ram_c) begin
      rd_data_c = mem[ram_idx_c];
    end else if (is_mmio_c) begin
      case (off_c)
        OFF_CYCLE_LO: rd_data_c = cycle[15:0];
        OFF_CYCLE_HI: rd_data_c = cycle_hi_snap;
        OFF_TIMER:    rd_data_c = timer_cmp;
        OFF_STATUS:   rd_data_c = {14'd0, bus_error, timer_irq};
        OFF_SCRATCH:  rd_data_c = scratch;
        default:      rd_data_c = '0;
      endcase
    end
  end

  // Error and interrupt set conditions for this edge.
  always_comb begin
    err_set_c   = 1'b0;
    status_wr_c = wr_c && is_mmio_c && (off_c == OFF_STATUS);
    if (ram_read_en && ram_write_en) err_set_c = 1'b1;
    if ((ram_read_en || ram_write_en) && !is_ram_c && !is_mmio_c) err_set_c = 1'b1;
    if ((ram_read_en || ram_write_en) && is_mmio_c && (off_c > OFF_SCRATCH)) err_set_c = 1'b1;
    if (wr_c && is_mmio_c && (off_c <= OFF_CYCLE_HI)) err_set_c = 1'b1;
    if (wr_c && prot_hit_c) err_set_c = 1'b1;
    irq_set_c = (timer_cmp != '0) && (cycle[15:0] == timer_cmp);
  end

  // RAM array: no reset; writes are suppressed while rst is high.
  always_ff @(posedge clk) begin
    if (!rst && wr_c && is_ram_c && !prot_hit_c) begin
      mem[ram_idx_c] <= ram_data_in;
    end
  end

  // Peripheral registers, read data and sticky flags (set beats W1C clear).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_data_out  <= '0;
      bus_error     <= 1'b0;
      timer_irq     <= 1'b0;
      cycle         <= '0;
      cycle_hi_snap <= '0;
      timer_cmp     <= '0;
      scratch       <= '0;
    end else begin
      cycle <= cycle + CW'(1);
      if (rd_c) begin
        ram_data_out <= rd_data_c;
        if (is_mmio_c && (off_c == OFF_CYCLE_LO)) cycle_hi_snap <= cycle[31:16];
      end
      if (wr_c && is_mmio_c && (off_c == OFF_TIMER))   timer_cmp <= ram_data_in;
      if (wr_c && is_mmio_c && (off_c == OFF_SCRATCH)) scratch   <= ram_data_in;
      timer_irq <= irq_set_c | (timer_irq & ~(status_wr_c & ram_data_in[0]));
      bus_error <= err_set_c | (bus_error & ~(status_wr_c & ram_data_in[1]));
    end
  end

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder with a read-data scoreboard queue.
module tb_memory_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ram_address_in = '0;
  logic [15:0] ram_data_in = '0;
  logic        ram_read_en = 1'b0;
  logic        ram_write_en = 1'b0;
  logic [15:0] ram_data_out;
  logic        bus_error;
  logic        timer_irq;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];
  logic [31:0] cyc;

  memory_responder dut (
    .clk(clk),
    .rst(rst),
    .ram_address_in(ram_address_in),
    .ram_data_in(ram_data_in),
    .ram_read_en(ram_read_en),
    .ram_write_en(ram_write_en),
    .ram_data_out(ram_data_out),
    .bus_error(bus_error),
    .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  // Reference cycle count: value the counter holds between edges.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 32'd0;
    else     cyc <= cyc + 32'd1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive at a negedge, return at the following negedge.
  task automatic drive(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
    ram_read_en = rd;
    ram_write_en = wr;
    ram_address_in = a;
    ram_data_in = d;
    @(negedge clk);
    ram_read_en = 1'b0;
    ram_write_en = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    logic [15:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL %s observed=%h expected=<empty scoreboard>", tag, ram_data_out);
    end else begin
      e = exp_q.pop_front();
      checks--;
      check(tag, 32'(ram_data_out), 32'(e));
    end
  endtask

  task automatic read_chk(input string tag, input logic [15:0] a, input logic [15:0] e);
    exp_q.push_back(e);
    drive(1'b1, 1'b0, a, 16'h0000);
    pop_check(tag);
  endtask

  task automatic wait_cyc(input string tag, input logic [31:0] target, input int budget);
    int n = 0;
    while (cyc != target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (cyc != target) check({tag, "_timeout"}, cyc, target);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    check("rst_data_out", 32'(ram_data_out), 32'h0);
    check("rst_bus_error", 32'(bus_error), 32'h0);
    check("rst_timer_irq", 32'(timer_irq), 32'h0);
    rst = 1'b0;

    // Timer compare and sticky irq.
    drive(1'b0, 1'b1, 16'hFF02, 16'h0040);
    read_chk("timer_cmp_rb", 16'hFF02, 16'h0040);
    wait_cyc("irq_pre", 32'h40, 200);
    check("irq_before_match", 32'(timer_irq), 32'h0);
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    check("irq_at_match", 32'(timer_irq), 32'h1);
    repeat (3) @(negedge clk);
    check("irq_sticky", 32'(timer_irq), 32'h1);
    drive(1'b0, 1'b1, 16'hFF03, 16'h0001);
    check("irq_w1c", 32'(timer_irq), 32'h0);

    // Write then read with hold across idle cycles.
    drive(1'b0, 1'b1, 16'h0100, 16'hBEEF);
    check("wr_no_data_change", 32'(ram_data_out), 32'h0040);
    read_chk("beef_read", 16'h0100, 16'hBEEF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("beef_hold", 32'(ram_data_out), 32'hBEEF);
    end

    // Unmapped read and W1C of bus_error.
    check("err_clean", 32'(bus_error), 32'h0);
    read_chk("unmapped_read", 16'h2000, 16'h0000);
    check("unmapped_err", 32'(bus_error), 32'h1);
    drive(1'b0, 1'b1, 16'hFF03, 16'h0002);
    check("err_w1c", 32'(bus_error), 32'h0);

    // Simultaneous read and write strobes.
    read_chk("pre_collide", 16'h0100, 16'hBEEF);
    drive(1'b1, 1'b1, 16'h0010, 16'h1234);
    check("collide_data_held", 32'(ram_data_out), 32'hBEEF);
    check("collide_err", 32'(bus_error), 32'h1);
    drive(1'b0, 1'b1, 16'hFF03, 16'h0002);
`ifndef RESPONDER_WPROT_EN
    read_chk("collide_write_done", 16'h0010, 16'h1234);
`endif

    // Protected-range write.
    drive(1'b0, 1'b1, 16'h0080, 16'hAAAA);
`ifdef RESPONDER_WPROT_EN
    check("wprot_err", 32'(bus_error), 32'h1);
    drive(1'b0, 1'b1, 16'hFF03, 16'h0002);
`else
    check("noprot_err", 32'(bus_error), 32'h0);
    read_chk("noprot_rb", 16'h0080, 16'hAAAA);
`endif

    // Scratch, RO write and reserved offsets.
    drive(1'b0, 1'b1, 16'hFF04, 16'hA5A5);
    read_chk("scratch_rb", 16'hFF04, 16'hA5A5);
    check("scratch_no_err", 32'(bus_error), 32'h0);
    drive(1'b0, 1'b1, 16'hFF00, 16'h1111);
    check("ro_write_err", 32'(bus_error), 32'h1);
    drive(1'b0, 1'b1, 16'hFF03, 16'h0002);
    read_chk("reserved_read", 16'hFF07, 16'h0000);
    check("reserved_err", 32'(bus_error), 32'h1);
    read_chk("status_read", 16'hFF03, 16'h0002);
    drive(1'b0, 1'b1, 16'hFF03, 16'h0002);

    // Coherent LO/HI read across the 16-bit wrap.
    wait_cyc("wrap", 32'h0000_FFFF, 70000);
    read_chk("cycle_lo", 16'hFF00, 16'hFFFF);
    read_chk("cycle_hi_snap", 16'hFF01, 16'h0000);

    // W1C coinciding with a compare match: set wins.
    check("irq_idle_low", 32'(timer_irq), 32'h0);
    wait_cyc("irq_match2", 32'h0001_0040, 200);
    drive(1'b0, 1'b1, 16'hFF03, 16'h0001);
    check("irq_set_beats_clr", 32'(timer_irq), 32'h1);
    drive(1'b0, 1'b1, 16'hFF03, 16'h0001);
    check("irq_clr_after", 32'(timer_irq), 32'h0);

    // Reset asserted at a write edge abandons the write.
    ram_read_en = 1'b0;
    ram_write_en = 1'b1;
    ram_address_in = 16'h0100;
    ram_data_in = 16'h1111;
    rst = 1'b1;
    @(negedge clk);
    ram_write_en = 1'b0;
    check("midrst_data_out", 32'(ram_data_out), 32'h0);
    check("midrst_timer_cmp_irq", 32'(timer_irq), 32'h0);
    rst = 1'b0;
    read_chk("midrst_ram_kept", 16'h0100, 16'hBEEF);
    read_chk("midrst_timer_cmp", 16'hFF02, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
